// File: rtl/mod_updown_counter.sv
// Parametrised up/down counter with load, wrap/saturate ends, cascade terminal count
// and a sticky overflow flag.
module mod_updown_counter #(
   parameter int unsigned      WIDTH     = 4,
   parameter logic [WIDTH-1:0] MAX_VALUE = '1,
   parameter bit               SATURATE  = 1'b0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             up,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             clr_ovf,
   output logic [WIDTH-1:0] Q,
   output logic             tc,
   output logic             wrap,
   output logic             ovf
);

   localparam logic [WIDTH-1:0] ZERO = '0;
   localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

   logic             at_end_c;
   logic [WIDTH-1:0] load_clamped_c;
   logic [WIDTH-1:0] q_next_c;
   logic             wrap_next_c;
   logic             ovf_next_c;

   // End condition depends on direction; tc is it gated by an actual count cycle.
   assign at_end_c = up ? (Q == MAX_VALUE) : (Q == ZERO);
   assign tc       = en & ~load & at_end_c;

   // A full-range modulus needs no clamp, and the comparison would be constant.
   generate
      if (MAX_VALUE == {WIDTH{1'b1}}) begin : g_no_clamp
         assign load_clamped_c = load_val;
      end else begin : g_clamp
         assign load_clamped_c = (load_val > MAX_VALUE) ? MAX_VALUE : load_val;
      end
   endgenerate

   // Next-state: load beats count; an end event sets ovf even against clr_ovf.
   always_comb begin
      q_next_c    = Q;
      wrap_next_c = 1'b0;
      ovf_next_c  = ovf & ~clr_ovf;
      if (load) begin
         q_next_c = load_clamped_c;
      end else if (en) begin
         if (at_end_c) begin
            wrap_next_c = 1'b1;
            ovf_next_c  = 1'b1;
            if (!SATURATE) begin
               q_next_c = up ? ZERO : MAX_VALUE;
            end
         end else begin
            q_next_c = up ? (Q + ONE) : (Q - ONE);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         Q    <= ZERO;
         wrap <= 1'b0;
         ovf  <= 1'b0;
      end else begin
         Q    <= q_next_c;
         wrap <= wrap_next_c;
         ovf  <= ovf_next_c;
      end
   end

endmodule

// File: tb/tb_mod_updown_counter.sv
// Bench for mod_updown_counter: directed scenarios then random stimulus, all checked
// against an integer reference model; includes a two-stage decimal cascade.
module tb_mod_updown_counter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // Index 0: W4/M9/wrap, 1: W4/M15/saturate, 2: W1/M1/wrap
   logic       rst [3];
   logic       en  [3];
   logic       up  [3];
   logic       ld  [3];
   logic       clr [3];
   logic [3:0] lv  [3];
   logic [0:0] lv2;
   assign lv2 = lv[2][0:0];

   logic [3:0] q0, q1;
   logic [0:0] q2;
   logic       tc0, tc1, tc2, w0, w1, w2, o0, o1, o2;

   logic       c_rst, c_en;
   logic [3:0] c_lo_q, c_hi_q;
   logic       c_lo_tc, c_hi_tc, c_lo_w, c_hi_w, c_lo_o, c_hi_o;

   mod_updown_counter #(.WIDTH(4), .MAX_VALUE(4'd9), .SATURATE(1'b0)) u_dec (
      .clk(clk), .reset(rst[0]), .en(en[0]), .up(up[0]), .load(ld[0]), .load_val(lv[0]),
      .clr_ovf(clr[0]), .Q(q0), .tc(tc0), .wrap(w0), .ovf(o0));

   mod_updown_counter #(.WIDTH(4), .MAX_VALUE(4'd15), .SATURATE(1'b1)) u_sat (
      .clk(clk), .reset(rst[1]), .en(en[1]), .up(up[1]), .load(ld[1]), .load_val(lv[1]),
      .clr_ovf(clr[1]), .Q(q1), .tc(tc1), .wrap(w1), .ovf(o1));

   mod_updown_counter #(.WIDTH(1), .MAX_VALUE(1'b1), .SATURATE(1'b0)) u_bit (
      .clk(clk), .reset(rst[2]), .en(en[2]), .up(up[2]), .load(ld[2]), .load_val(lv2),
      .clr_ovf(clr[2]), .Q(q2), .tc(tc2), .wrap(w2), .ovf(o2));

   mod_updown_counter #(.WIDTH(4), .MAX_VALUE(4'd9), .SATURATE(1'b0)) u_lo (
      .clk(clk), .reset(c_rst), .en(c_en), .up(1'b1), .load(1'b0), .load_val(4'd0),
      .clr_ovf(1'b0), .Q(c_lo_q), .tc(c_lo_tc), .wrap(c_lo_w), .ovf(c_lo_o));

   mod_updown_counter #(.WIDTH(4), .MAX_VALUE(4'd9), .SATURATE(1'b0)) u_hi (
      .clk(clk), .reset(c_rst), .en(c_lo_tc), .up(1'b1), .load(1'b0), .load_val(4'd0),
      .clr_ovf(1'b0), .Q(c_hi_q), .tc(c_hi_tc), .wrap(c_hi_w), .ovf(c_hi_o));

   int nerr = 0;
   int nchk = 0;

   // Reference model: plain integers
   int mq [3];
   int mw [3];
   int mo [3];
   int maxv [3] = '{9, 15, 1};
   int sat  [3] = '{0, 1, 0};
   int ccnt;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nchk++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // One clock: check tc before the edge, advance the model, check registers after it.
   task automatic step();
      logic [31:0] oq [3];
      logic [31:0] ot [3];
      logic [31:0] ow [3];
      logic [31:0] oo [3];
      int          etc, lvv, q;
      bit          ev;
      #1;
      ot[0] = 32'(tc0); ot[1] = 32'(tc1); ot[2] = 32'(tc2);
      for (int i = 0; i < 3; i++) begin
         etc = (en[i] && !ld[i] && ((up[i] && mq[i] == maxv[i]) || (!up[i] && mq[i] == 0))) ? 1 : 0;
         check($sformatf("tc[%0d]", i), ot[i], 32'(etc));
      end
      check("cascade_lo_tc", 32'(c_lo_tc), (c_en && (ccnt % 10) == 9) ? 32'd1 : 32'd0);

      for (int i = 0; i < 3; i++) begin
         lvv = (i == 2) ? int'(lv[i][0]) : int'(lv[i]);
         q   = mq[i];
         if (rst[i]) begin
            mq[i] = 0; mw[i] = 0; mo[i] = 0;
         end else if (ld[i]) begin
            mq[i] = (lvv > maxv[i]) ? maxv[i] : lvv;
            mw[i] = 0;
            if (clr[i]) mo[i] = 0;
         end else if (en[i]) begin
            ev = up[i] ? (q == maxv[i]) : (q == 0);
            if (ev) begin
               mw[i] = 1; mo[i] = 1;
               if (sat[i] == 0) mq[i] = up[i] ? 0 : maxv[i];
            end else begin
               mw[i] = 0;
               mq[i] = up[i] ? q + 1 : q - 1;
               if (clr[i]) mo[i] = 0;
            end
         end else begin
            mw[i] = 0;
            if (clr[i]) mo[i] = 0;
         end
      end
      if (c_rst) ccnt = 0;
      else if (c_en) ccnt = (ccnt + 1) % 100;

      @(posedge clk);
      #1;
      oq[0] = 32'(q0); oq[1] = 32'(q1); oq[2] = 32'(q2);
      ow[0] = 32'(w0); ow[1] = 32'(w1); ow[2] = 32'(w2);
      oo[0] = 32'(o0); oo[1] = 32'(o1); oo[2] = 32'(o2);
      for (int i = 0; i < 3; i++) begin
         check($sformatf("Q[%0d]", i),    oq[i], 32'(mq[i]));
         check($sformatf("wrap[%0d]", i), ow[i], 32'(mw[i]));
         check($sformatf("ovf[%0d]", i),  oo[i], 32'(mo[i]));
      end
      check("cascade_lo", 32'(c_lo_q), 32'(ccnt % 10));
      check("cascade_hi", 32'(c_hi_q), 32'(ccnt / 10));
      @(negedge clk);
   endtask

   initial begin
      for (int i = 0; i < 3; i++) begin
         rst[i] = 1'b1; en[i] = 1'b0; up[i] = 1'b0; ld[i] = 1'b0; clr[i] = 1'b0; lv[i] = 4'd0;
         mq[i] = 0; mw[i] = 0; mo[i] = 0;
      end
      c_rst = 1'b1; c_en = 1'b0; ccnt = 0;
      @(negedge clk);
      step(); step();
      for (int i = 0; i < 3; i++) rst[i] = 1'b0;
      c_rst = 1'b0;

      // Count up through the decade wrap
      en[0] = 1'b1; up[0] = 1'b1;
      repeat (12) step();
      check("t1_q_end", 32'(q0), 32'd2);
      check("t1_ovf", 32'(o0), 32'd1);

      // Load 3 then count down through 0 to 9
      en[0] = 1'b0; ld[0] = 1'b1; lv[0] = 4'd3;
      step();
      ld[0] = 1'b0; en[0] = 1'b1; up[0] = 1'b0;
      repeat (5) step();
      check("t2_q_end", 32'(q0), 32'd8);
      en[0] = 1'b0;

      // Saturating counter held at 15, then clr_ovf alone and with an end event
      ld[1] = 1'b1; lv[1] = 4'd14;
      step();
      ld[1] = 1'b0; en[1] = 1'b1; up[1] = 1'b1;
      repeat (4) step();
      check("t3_q_held", 32'(q1), 32'd15);
      check("t3_wrap_held", 32'(w1), 32'd1);
      en[1] = 1'b0; clr[1] = 1'b1;
      step();
      check("t3_clr_alone", 32'(o1), 32'd0);
      en[1] = 1'b1;
      step();
      check("t3_clr_vs_set", 32'(o1), 32'd1);
      en[1] = 1'b0; clr[1] = 1'b0;

      // Load clamp and priorities
      ld[0] = 1'b1; lv[0] = 4'd12;
      step();
      check("t4_clamp", 32'(q0), 32'd9);
      en[0] = 1'b1; up[0] = 1'b1; lv[0] = 4'd5;
      step();
      check("t4_load_over_en", 32'(q0), 32'd5);
      check("t4_load_wrap", 32'(w0), 32'd0);
      rst[0] = 1'b1; lv[0] = 4'd7;
      step();
      check("t4_reset_over_load", 32'(q0), 32'd0);
      rst[0] = 1'b0; en[0] = 1'b0;

      // Reset in the middle of counting
      step();
      ld[0] = 1'b0; en[0] = 1'b1; rst[0] = 1'b1;
      step();
      check("t6_rst_q", 32'(q0), 32'd0);
      check("t6_rst_ovf", 32'(o0), 32'd0);
      rst[0] = 1'b0;
      step();
      check("t6_restart", 32'(q0), 32'd1);
      en[0] = 1'b0;

      // One-bit, modulus-1 counter in both directions
      en[2] = 1'b1; up[2] = 1'b1;
      repeat (4) step();
      up[2] = 1'b0;
      repeat (4) step();
      en[2] = 1'b0;

      // Decimal cascade
      c_en = 1'b1;
      repeat (25) step();
      check("t5_hi", 32'(c_hi_q), 32'd2);
      check("t5_lo", 32'(c_lo_q), 32'd5);

      // Random traffic on all instances
      repeat (300) begin
         for (int i = 0; i < 3; i++) begin
            rst[i] = ($urandom_range(0, 31) == 0);
            ld[i]  = ($urandom_range(0, 7) == 0);
            en[i]  = ($urandom_range(0, 3) != 0);
            up[i]  = 1'($urandom_range(0, 1));
            clr[i] = ($urandom_range(0, 7) == 0);
            lv[i]  = 4'($urandom_range(0, 15));
         end
         c_en  = 1'($urandom_range(0, 1));
         c_rst = ($urandom_range(0, 63) == 0);
         step();
      end

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
